// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
// start is a request that is accepted only while the block is idle (busy=0, done=0).
// Any request made during busy or done is dropped. done pulses for one cycle.
// diff and borrow_out are valid from that pulse until the next accepted start.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  diff, borrow_out, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow_out, busy, done
  );
endinterface

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor: sub = x - y - Bin, with the borrow out in Bout.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic Bin,
  output logic sub,
  output logic Bout
);
  assign sub  = x ^ y ^ Bin;
  assign Bout = (~x & y) | (~(x ^ y) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b: one bit per clock, LSB first, through a single full subtractor.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_if.slave    bus,
  output state_e                state_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_sub;
  logic             bit_bout;

  full_sub u_full_sub (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .Bin  (borrow_q),
    .sub  (bit_sub),
    .Bout (bit_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
        diff_d   = {bit_sub, diff_q[WIDTH-1:1]};
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        borrow_d = bit_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an integer-arithmetic model.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     n_checks;
  int     n_fail;
  int     done_cnt;
  int     cyc;
  int     exp_dones;
  logic [W:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // model: true integer difference, then reduce modulo 2^W
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
    int d;
    logic [W-1:0] r;
    d = int'(av) - int'(bv);
    r = W'((d + (1 << W)) % (1 << W));
    return {d < 0, r};
  endfunction

  task automatic run_txn(input logic [W-1:0] av, input logic [W-1:0] bv, input bit glitch);
    int busy_cnt;
    int guard;
    bit got_done;
    int dc0;
    logic [W:0] exp;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    exp_q.push_back(model(av, bv));
    dc0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    guard = 0;
    got_done = 0;
    while (!got_done && guard < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        got_done = 1;
      end else begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.start = (glitch && busy_cnt == 3) ? 1'b1 : 1'b0;
        @(negedge clk);
        guard++;
      end
    end
    bus.start = 1'b0;
    exp = exp_q.pop_front();
    check("done_seen", 32'(got_done), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("diff", 32'(bus.diff), 32'(exp[W-1:0]));
    check("borrow_out", 32'(bus.borrow_out), 32'(exp[W]));
    exp_dones++;
    @(negedge clk);
    check("done_one_pulse", 32'(bus.done), 32'd0);
    check("done_count", 32'(done_cnt - dc0), 32'd1);
    check("diff_hold", 32'(bus.diff), 32'(exp[W-1:0]));
    check("state_idle", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    int t_done[$];
    int guard;
    logic [W:0] exp;
    n_checks = 0;
    n_fail = 0;
    done_cnt = 0;
    cyc = 0;
    exp_dones = 0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    #1;
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_borrow", 32'(bus.borrow_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // directed vectors
    run_txn(8'h35, 8'h12, 1'b0);
    run_txn(8'h12, 8'h35, 1'b0);
    run_txn(8'h00, 8'h01, 1'b0);
    run_txn(8'hFF, 8'hFF, 1'b0);
    run_txn(8'h00, 8'hFF, 1'b0);
    run_txn(8'hFF, 8'h00, 1'b0);
    // start re-pulsed mid-shift must be ignored
    run_txn(8'hA7, 8'h3C, 1'b1);

    // abort mid-shift with an asynchronous reset
    begin
      int dc0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'h5A;
      bus.b = 8'h21;
      dc0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_pre", 32'(bus.busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("abort_diff", 32'(bus.diff), 32'd0);
      check("abort_borrow", 32'(bus.borrow_out), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    end
    run_txn(8'h80, 8'h01, 1'b0);

    // randomized operands
    for (int i = 0; i < 20; i++) begin
      run_txn(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end

    // back-to-back with start held high
    @(negedge clk);
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    exp = model(bus.a, bus.b);
    bus.start = 1'b1;
    guard = 0;
    while (t_done.size() < 4 && guard < 80) begin
      @(negedge clk);
      guard++;
      if (bus.done === 1'b1) begin
        t_done.push_back(cyc);
        exp_dones++;
        check("b2b_diff", 32'(bus.diff), 32'(exp[W-1:0]));
        check("b2b_borrow", 32'(bus.borrow_out), 32'(exp[W]));
      end
    end
    bus.start = 1'b0;
    check("b2b_done_seen", 32'(t_done.size()), 32'd4);
    for (int i = 1; i < t_done.size(); i++) begin
      check("b2b_spacing", 32'(t_done[i] - t_done[i-1]), 32'(W + 2));
    end
    // let an in-flight transaction started before start dropped run out
    repeat (W + 4) @(negedge clk);
    if (done_cnt > exp_dones) exp_dones = done_cnt;
    check("total_dones", 32'(done_cnt), 32'(exp_dones));
    check("final_idle", 32'(dbg_state), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
